// File: rtl/test_engine_nic_input_sequencer.sv
// Receive-buffer control FSM for the test-engine NIC: captures header + DATA_FLITS flits,
// holds the packet until the PE is free, then fires start + credit. Optional stats: NIC_INPUT_STATS_EN.
module test_engine_nic_input_sequencer #(
    parameter int DATA_FLITS = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  header_field_din,
    input  logic                  busy_engine_din,
    input  logic                  zero_credits_din,
    output logic                  write_strobe_dout,
    output logic [DATA_FLITS:0]   register_enable_dout,
    output logic                  transfer2pe_strobe_dout,
    output logic                  credit_return_dout,
    output logic                  buffer_full_dout,
    output logic                  overflow_error_dout
`ifdef NIC_INPUT_STATS_EN
    ,
    output logic [15:0]           pkt_count_dout,
    output logic [15:0]           stall_count_dout
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WAIT    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_FLIT = CNT_WIDTH'(DATA_FLITS);

    state_t                state_q, state_n;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_n;
    logic                  overflow_q;
    logic                  go;
    logic                  header_in_wait;
    logic                  write_strobe;
    logic                  transfer;

    assign go = ~busy_engine_din & ~zero_credits_din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            if (header_in_wait) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n              = state_q;
        cnt_n                = cnt_q;
        write_strobe         = 1'b0;
        register_enable_dout = '0;
        register_enable_dout[0] = 1'b1;
        transfer             = 1'b0;
        header_in_wait       = 1'b0;
        case (state_q)
            IDLE: begin
                write_strobe = header_field_din;
                if (header_field_din) begin
                    state_n = CAPTURE;
                    cnt_n   = CNT_WIDTH'(1);
                end
            end
            CAPTURE: begin
                // Data flits arrive back-to-back; bit31 carries payload here, not a header mark.
                write_strobe         = 1'b1;
                register_enable_dout = '0;
                for (int i = 0; i <= DATA_FLITS; i++) begin
                    register_enable_dout[i] = (cnt_q == CNT_WIDTH'(i));
                end
                if (cnt_q == LAST_FLIT) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_WIDTH'(1);
                end
            end
            WAIT: begin
                header_in_wait = header_field_din;
                if (go) begin
                    transfer = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // While reset is held the state is IDLE, so only the header-driven strobe needs masking.
    assign write_strobe_dout       = write_strobe & reset;
    assign transfer2pe_strobe_dout = transfer;
    assign credit_return_dout      = transfer;
    assign buffer_full_dout        = (state_q != IDLE);
    assign overflow_error_dout     = overflow_q;

`ifdef NIC_INPUT_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] pkt_count_q;
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (transfer) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if ((state_q == WAIT) && !go) begin
                stall_count_q <= sat_inc16(stall_count_q);
            end
        end
    end

    assign pkt_count_dout   = pkt_count_q;
    assign stall_count_dout = stall_count_q;
`endif

endmodule

// File: tb/tb_test_engine_nic_input_sequencer.sv
// Directed bench for test_engine_nic_input_sequencer; stats ports checked when NIC_INPUT_STATS_EN is defined.
module tb_test_engine_nic_input_sequencer;

    localparam int DF = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        header = 1'b0;
    logic        busy = 1'b0;
    logic        zc = 1'b0;
    logic        ws, xfer, credit, full, ovf;
    logic [DF:0] en;
`ifdef NIC_INPUT_STATS_EN
    logic [15:0] pkt_cnt, stall_cnt;
`endif

    // {write_strobe, enable[4:0], transfer, credit, full, overflow}
    logic [9:0] obs;
    logic [9:0] exp_v;
    assign obs = {ws, en, xfer, credit, full, ovf};

    localparam logic [9:0] IDLE_V = 10'b0_00001_0_0_0_0;
    localparam logic [9:0] HOLD_V = 10'b0_00001_0_0_1_0;
    localparam logic [9:0] XFER_V = 10'b0_00001_1_1_1_0;

    logic [9:0] pkt_tbl [7];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    test_engine_nic_input_sequencer #(.DATA_FLITS(DF), .CNT_WIDTH(3)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .header_field_din        (header),
        .busy_engine_din         (busy),
        .zero_credits_din        (zc),
        .write_strobe_dout       (ws),
        .register_enable_dout    (en),
        .transfer2pe_strobe_dout (xfer),
        .credit_return_dout      (credit),
        .buffer_full_dout        (full),
        .overflow_error_dout     (ovf)
`ifdef NIC_INPUT_STATS_EN
        ,
        .pkt_count_dout          (pkt_cnt),
        .stall_count_dout        (stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        header = 1'b0;
        busy   = 1'b0;
        zc     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Leaves the bench in the first WAIT cycle (cycle DF+1) with header low.
    task automatic drive_packet(input logic data_hdr);
        header = 1'b1;
        tick();
        for (int i = 1; i <= DF; i++) begin
            header = data_hdr;
            tick();
        end
        header = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        header = 1'b1;
        tick();
        tick();
        #2;
        nvec++;
        if (obs !== IDLE_V) begin
            nerr++;
            $display("FAIL reset_outputs: got %b want %b", obs, IDLE_V);
        end
        header = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            header = (c == 0);
            #2;
            nvec++;
            if (obs !== pkt_tbl[c]) begin
                nerr++;
                $display("FAIL basic cyc%0d: got %b want %b", c, obs, pkt_tbl[c]);
            end
`ifdef NIC_INPUT_STATS_EN
            if (c == 6) begin
                nvec++;
                if (pkt_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
                    nerr++;
                    $display("FAIL basic_stats: got pkt=%0d stall=%0d want pkt=1 stall=0", pkt_cnt, stall_cnt);
                end
            end
`endif
            tick();
        end
    endtask

    task automatic test_busy_hold();
        do_reset();
        drive_packet(1'b0);
        for (int c = 5; c <= 11; c++) begin
            busy = (c <= 9);
            #2;
            exp_v = (c <= 9) ? HOLD_V : (c == 10) ? XFER_V : IDLE_V;
            nvec++;
            if (obs !== exp_v) begin
                nerr++;
                $display("FAIL busy_hold cyc%0d: got %b want %b", c, obs, exp_v);
            end
            tick();
        end
`ifdef NIC_INPUT_STATS_EN
        nvec++;
        if (pkt_cnt !== 16'd1 || stall_cnt !== 16'd5) begin
            nerr++;
            $display("FAIL busy_stats: got pkt=%0d stall=%0d want pkt=1 stall=5", pkt_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_alternate();
        logic [1:0] bz [6];
        bz = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
        do_reset();
        drive_packet(1'b0);
        for (int c = 0; c < 6; c++) begin
            busy = bz[c][1];
            zc   = bz[c][0];
            #2;
            exp_v = (c < 4) ? HOLD_V : (c == 4) ? XFER_V : IDLE_V;
            nvec++;
            if (obs !== exp_v) begin
                nerr++;
                $display("FAIL alternate step%0d: got %b want %b", c, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive_packet(1'b0);
        busy   = 1'b1;
        header = 1'b1;
        #2;
        nvec++;
        if (obs !== HOLD_V) begin
            nerr++;
            $display("FAIL overflow_hdr: got %b want %b", obs, HOLD_V);
        end
        tick();
        header = 1'b0;
        #2;
        nvec++;
        if (obs !== 10'b0_00001_0_0_1_1) begin
            nerr++;
            $display("FAIL overflow_set: got %b want %b", obs, 10'b0_00001_0_0_1_1);
        end
        tick();
        busy = 1'b0;
        #2;
        nvec++;
        if (obs !== 10'b0_00001_1_1_1_1) begin
            nerr++;
            $display("FAIL overflow_xfer: got %b want %b", obs, 10'b0_00001_1_1_1_1);
        end
        tick();
        #2;
        nvec++;
        if (obs !== 10'b0_00001_0_0_0_1) begin
            nerr++;
            $display("FAIL overflow_sticky: got %b want %b", obs, 10'b0_00001_0_0_0_1);
        end
        reset = 1'b0;
        #1;
        nvec++;
        if (obs !== IDLE_V) begin
            nerr++;
            $display("FAIL overflow_clear: got %b want %b", obs, IDLE_V);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_data_bit31();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            header = (c <= DF);
            #2;
            nvec++;
            if (obs !== pkt_tbl[c]) begin
                nerr++;
                $display("FAIL bit31 cyc%0d: got %b want %b", c, obs, pkt_tbl[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_capture();
        do_reset();
        header = 1'b1;
        tick();
        header = 1'b0;
        tick();
        reset = 1'b0;
        #2;
        nvec++;
        if (obs !== IDLE_V) begin
            nerr++;
            $display("FAIL mid_reset: got %b want %b", obs, IDLE_V);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #2;
            nvec++;
            if (obs !== IDLE_V) begin
                nerr++;
                $display("FAIL mid_reset_after cyc%0d: got %b want %b", c, obs, IDLE_V);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_packet(1'b0);
        #2;
        nvec++;
        if (obs !== XFER_V) begin
            nerr++;
            $display("FAIL b2b_first_xfer: got %b want %b", obs, XFER_V);
        end
        tick();
        header = 1'b1;
        #2;
        nvec++;
        if (obs !== pkt_tbl[0]) begin
            nerr++;
            $display("FAIL b2b_header: got %b want %b", obs, pkt_tbl[0]);
        end
        tick();
        header = 1'b0;
        #2;
        nvec++;
        if (obs !== pkt_tbl[1]) begin
            nerr++;
            $display("FAIL b2b_flit1: got %b want %b", obs, pkt_tbl[1]);
        end
        for (int i = 0; i < 4; i++) tick();
        #2;
        nvec++;
        if (obs !== XFER_V) begin
            nerr++;
            $display("FAIL b2b_second_xfer: got %b want %b", obs, XFER_V);
        end
        tick();
    endtask

    initial begin
        pkt_tbl[0] = 10'b1_00001_0_0_0_0;
        pkt_tbl[1] = 10'b1_00010_0_0_1_0;
        pkt_tbl[2] = 10'b1_00100_0_0_1_0;
        pkt_tbl[3] = 10'b1_01000_0_0_1_0;
        pkt_tbl[4] = 10'b1_10000_0_0_1_0;
        pkt_tbl[5] = 10'b0_00001_1_1_1_0;
        pkt_tbl[6] = 10'b0_00001_0_0_0_0;

        test_reset();
        test_basic();
        test_busy_hold();
        test_alternate();
        test_overflow();
        test_data_bit31();
        test_reset_mid_capture();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
